// File: rtl/dekatron_counter_arbiter.sv
// Two-client sequencer/arbiter that turns inc/dec/set-by-N commands into single-step
// DekatronCounter handshakes. Define DEKATRON_ARB_ROUND_ROBIN_EN for round-robin ties.
module dekatron_counter_arbiter #(
  parameter int D_NUM  = 6,
  parameter int STEP_W = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Req0,
  input  logic                 Req1,
  input  logic                 Dec0,
  input  logic                 Dec1,
  input  logic                 Set0,
  input  logic                 Set1,
  input  logic [STEP_W-1:0]    Steps0,
  input  logic [STEP_W-1:0]    Steps1,
  input  logic [D_NUM*4-1:0]   In0,
  input  logic [D_NUM*4-1:0]   In1,
  output logic                 Ack0,
  output logic                 Ack1,
  output logic                 Done0,
  output logic                 Done1,
  output logic                 Busy,
  output logic                 CntRequest,
  output logic                 CntDec,
  output logic                 CntSet,
  output logic [D_NUM*4-1:0]   CntIn,
  input  logic                 CntReady
);

  typedef enum logic [2:0] {IDLE, ISSUE, LAT, WAIT, DONE} state_t;

  state_t              state, state_nxt;
  logic [STEP_W-1:0]   remaining, remaining_nxt;
  logic                owner;
  logic                any_req;
  logic                win;
  logic                grant;
  logic                sel_dec;
  logic                sel_set;
  logic [STEP_W-1:0]   sel_steps;
  logic [D_NUM*4-1:0]  sel_in;

  assign any_req = Req0 | Req1;
  assign grant   = (state == IDLE) && any_req;

`ifdef DEKATRON_ARB_ROUND_ROBIN_EN
  logic prio;  // client favoured on the next tie

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)        prio <= 1'b0;
    else if (grant) prio <= ~win;
  end

  assign win = (Req0 && Req1) ? prio : Req1;
`else
  assign win = ~Req0;
`endif

  assign sel_dec   = win ? Dec1   : Dec0;
  assign sel_set   = win ? Set1   : Set0;
  assign sel_steps = win ? Steps1 : Steps0;
  assign sel_in    = win ? In1    : In0;

  // Ack is combinational in the grant cycle; gate with Rst so reset forces it low at once.
  assign Ack0 = grant & ~Rst & ~win;
  assign Ack1 = grant & ~Rst &  win;
  assign Busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments; every register here,
  // including the latched command, is cleared by the asynchronous reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      remaining <= '0;
      owner     <= 1'b0;
      CntDec    <= 1'b0;
      CntSet    <= 1'b0;
      CntIn     <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      if (grant) begin
        owner  <= win;
        CntDec <= sel_dec;
        CntSet <= sel_set;
        CntIn  <= sel_in;
      end
    end
  end

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    CntRequest    = 1'b0;
    Done0         = 1'b0;
    Done1         = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          if (sel_set) begin
            remaining_nxt = STEP_W'(1);
            state_nxt     = ISSUE;
          end else if (sel_steps == '0) begin
            state_nxt     = DONE;
          end else begin
            remaining_nxt = sel_steps;
            state_nxt     = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (CntReady) begin
          CntRequest = 1'b1;
          state_nxt  = LAT;
        end
      end
      // Ready may still show its pre-request value here, so it is ignored.
      LAT: state_nxt = WAIT;
      WAIT: begin
        if (CntReady) begin
          remaining_nxt = remaining - STEP_W'(1);
          state_nxt     = (remaining == STEP_W'(1)) ? DONE : ISSUE;
        end
      end
      DONE: begin
        Done0     = ~owner;
        Done1     =  owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dekatron_counter_arbiter.sv
// Self-checking bench for dekatron_counter_arbiter: behavioural command-level model,
// a simple counter model with random Ready stalls, directed cases and random traffic.
module tb_dekatron_counter_arbiter;
  localparam int D_NUM  = 6;
  localparam int STEP_W = 8;
  localparam int DW     = D_NUM * 4;
  localparam int MOD    = 10 ** D_NUM;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              Req0, Req1, Dec0, Dec1, Set0, Set1;
  logic [STEP_W-1:0] Steps0, Steps1;
  logic [DW-1:0]     In0, In1;
  logic              Ack0, Ack1, Done0, Done1, Busy, CntRequest, CntDec, CntSet;
  logic [DW-1:0]     CntIn;
  logic              CntReady;

  always #5 Clk = ~Clk;

  dekatron_counter_arbiter #(.D_NUM(D_NUM), .STEP_W(STEP_W)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req0(Req0), .Req1(Req1), .Dec0(Dec0), .Dec1(Dec1), .Set0(Set0), .Set1(Set1),
    .Steps0(Steps0), .Steps1(Steps1), .In0(In0), .In1(In1),
    .Ack0(Ack0), .Ack1(Ack1), .Done0(Done0), .Done1(Done1), .Busy(Busy),
    .CntRequest(CntRequest), .CntDec(CntDec), .CntSet(CntSet), .CntIn(CntIn),
    .CntReady(CntReady)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the command in flight, its remaining steps, and whether a
  // counter step has been requested and not yet acknowledged.
  bit          m_active;
  int          m_owner;
  bit          m_dec, m_set;
  logic [DW-1:0] m_in;
  int          m_left;
  bit          m_outstanding;
  bit          m_just_issued;
  int          m_prio;

  // Counter model and tallies.
  int          cnt_val;
  int          cnt_busy;
  int          busy_max;
  int          glitch_pct;
  int          cyc;
  int          n_req;
  int          n_ack [2];
  int          n_done[2];
  int          ack_cyc [2];
  int          done_cyc[2];
  bit          dut_done[2];
  bit          exp_done[2];
  bit          last_req_dec, last_req_set;
  logic [DW-1:0] last_req_in;
  int          grants[$];

  function automatic int bcd2int(input logic [DW-1:0] v);
    int r = 0;
    for (int i = D_NUM - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_bcd();
    logic [DW-1:0] v = '0;
    for (int i = 0; i < D_NUM; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic clear_tally();
    n_req = 0;
    for (int k = 0; k < 2; k++) begin
      n_ack[k] = 0; n_done[k] = 0; ack_cyc[k] = -1; done_cyc[k] = -1;
    end
  endtask

  task automatic drive_client(input int k, input logic r, input logic d, input logic s,
                              input logic [STEP_W-1:0] st, input logic [DW-1:0] v);
    if (k == 0) begin Req0 = r; Dec0 = d; Set0 = s; Steps0 = st; In0 = v; end
    else        begin Req1 = r; Dec1 = d; Set1 = s; Steps1 = st; In1 = v; end
  endtask

  // One clock cycle: compare at the falling edge, advance models, then move to the
  // drive window just after the next rising edge.
  task automatic tick();
    bit e_ack0, e_ack1, e_done0, e_done1, e_req, e_busy, e_dec, e_set;
    logic [DW-1:0] e_in;
    int win;
    @(negedge Clk);
    cyc++;
    win = -1;
    e_ack0 = 0; e_ack1 = 0; e_done0 = 0; e_done1 = 0; e_req = 0; e_busy = 0;
    e_dec = 0; e_set = 0; e_in = '0;
    if (!Rst) begin
      e_busy = m_active;
      e_dec  = m_dec; e_set = m_set; e_in = m_in;
      if (!m_active && (Req0 || Req1)) begin
`ifdef DEKATRON_ARB_ROUND_ROBIN_EN
        win = (Req0 && Req1) ? m_prio : (Req0 ? 0 : 1);
`else
        win = Req0 ? 0 : 1;
`endif
        e_ack0 = (win == 0);
        e_ack1 = (win == 1);
      end
      if (m_active && m_left == 0) begin
        e_done0 = (m_owner == 0);
        e_done1 = (m_owner == 1);
      end
      e_req = m_active && m_left > 0 && !m_outstanding && CntReady;
    end

    check("Ack0", Ack0, e_ack0);
    check("Ack1", Ack1, e_ack1);
    check("Done0", Done0, e_done0);
    check("Done1", Done1, e_done1);
    check("Busy", Busy, e_busy);
    check("CntRequest", CntRequest, e_req);
    check("CntDec", CntDec, e_dec);
    check("CntSet", CntSet, e_set);
    check("CntIn", CntIn, e_in);

    exp_done[0] = e_done0;
    exp_done[1] = e_done1;
    dut_done[0] = (Done0 === 1'b1);
    dut_done[1] = (Done1 === 1'b1);
    if (Ack0 === 1'b1) begin n_ack[0]++; grants.push_back(0); if (ack_cyc[0] < 0) ack_cyc[0] = cyc; end
    if (Ack1 === 1'b1) begin n_ack[1]++; grants.push_back(1); if (ack_cyc[1] < 0) ack_cyc[1] = cyc; end
    if (dut_done[0]) begin n_done[0]++; done_cyc[0] = cyc; end
    if (dut_done[1]) begin n_done[1]++; done_cyc[1] = cyc; end

    // The counter acts on whatever the DUT actually presents.
    if (CntRequest === 1'b1) begin
      n_req++;
      last_req_dec = CntDec; last_req_set = CntSet; last_req_in = CntIn;
      if (CntSet)      cnt_val = bcd2int(CntIn) % MOD;
      else if (CntDec) cnt_val = (cnt_val + MOD - 1) % MOD;
      else             cnt_val = (cnt_val + 1) % MOD;
      cnt_busy = $urandom_range(0, busy_max);
    end

    if (Rst) begin
      m_active = 0; m_dec = 0; m_set = 0; m_in = '0; m_left = 0;
      m_outstanding = 0; m_just_issued = 0; m_prio = 0;
    end else if (!m_active) begin
      if (win >= 0) begin
        m_active = 1;
        m_owner  = win;
        m_dec    = (win == 0) ? Dec0 : Dec1;
        m_set    = (win == 0) ? Set0 : Set1;
        m_in     = (win == 0) ? In0  : In1;
        m_left   = m_set ? 1 : int'((win == 0) ? Steps0 : Steps1);
        m_outstanding = 0;
        m_just_issued = 0;
        m_prio   = 1 - win;
      end
    end else if (m_left == 0) begin
      m_active = 0;
    end else if (!m_outstanding) begin
      if (CntReady) begin m_outstanding = 1; m_just_issued = 1; end
    end else if (m_just_issued) begin
      m_just_issued = 0;
    end else if (CntReady) begin
      m_outstanding = 0;
      m_left--;
    end

    @(posedge Clk);
    #1;
    CntReady = (cnt_busy == 0) && ($urandom_range(0, 99) >= glitch_pct);
    if (cnt_busy > 0) cnt_busy--;
  endtask

  task automatic run_cmd(input int k, input logic d, input logic s,
                         input logic [STEP_W-1:0] st, input logic [DW-1:0] v);
    bit seen = 0;
    clear_tally();
    drive_client(k, 1'b1, d, s, st, v);
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      seen = dut_done[k];
    end
    check("cmd_done_within_budget", seen, 1);
    drive_client(k, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) tick();
  endtask

  int left[2];
  int exp_order[4];
  bit pend[2];

  initial begin
    Rst = 1'b1; CntReady = 1'b1;
    drive_client(0, 0, 0, 0, '0, '0);
    drive_client(1, 0, 0, 0, '0, '0);
    m_active = 0; m_dec = 0; m_set = 0; m_in = '0; m_left = 0; m_owner = 0;
    m_outstanding = 0; m_just_issued = 0; m_prio = 0;
    cnt_val = 0; cnt_busy = 0; busy_max = 0; glitch_pct = 0; cyc = 0;
    clear_tally();
    @(posedge Clk); #1;
    tick();
    check("reset_Busy", Busy, 0);
    check("reset_CntRequest", CntRequest, 0);
    check("reset_CntIn", CntIn, 0);
    check("reset_Done", {Done0, Done1}, 0);
    Rst = 1'b0;
    repeat (2) tick();

    // Increment by 5 from 0: 3 cycles per step, Done at t+3N+1.
    run_cmd(0, 1'b0, 1'b0, 8'd5, '0);
    check("inc5_requests", n_req, 5);
    check("inc5_ack0", n_ack[0], 1);
    check("inc5_done0", n_done[0], 1);
    check("inc5_counter", cnt_val, 5);
    check("inc5_latency", done_cyc[0] - ack_cyc[0], 16);
    check("inc5_dir", last_req_dec, 0);

    // Decrement by 5 from client 1.
    run_cmd(1, 1'b1, 1'b0, 8'd5, '0);
    check("dec5_requests", n_req, 5);
    check("dec5_done1", n_done[1], 1);
    check("dec5_done0", n_done[0], 0);
    check("dec5_counter", cnt_val, 0);
    check("dec5_dir", last_req_dec, 1);

    // Parallel set ignores Steps.
    run_cmd(0, 1'b0, 1'b1, 8'd9, 24'h123456);
    check("set_requests", n_req, 1);
    check("set_flag", last_req_set, 1);
    check("set_value", last_req_in, 24'h123456);
    check("set_counter", cnt_val, 123456);

    // Zero-step command never touches the counter.
    run_cmd(0, 1'b0, 1'b0, 8'd0, '0);
    check("zero_requests", n_req, 0);
    check("zero_latency", done_cyc[0] - ack_cyc[0], 1);

    // Both clients held for two one-step commands each, starting from reset.
    Rst = 1'b1; tick(); Rst = 1'b0;
    clear_tally(); grants.delete();
    left[0] = 2; left[1] = 2;
    drive_client(0, 1'b1, 1'b0, 1'b0, 8'd1, '0);
    drive_client(1, 1'b1, 1'b0, 1'b0, 8'd1, '0);
    for (int i = 0; i < 300 && (left[0] > 0 || left[1] > 0); i++) begin
      tick();
      for (int k = 0; k < 2; k++)
        if (dut_done[k] && left[k] > 0) begin
          left[k]--;
          if (left[k] == 0) drive_client(k, 1'b0, 1'b0, 1'b0, '0, '0);
        end
    end
    repeat (3) tick();
`ifdef DEKATRON_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 1, 1};
`endif
    check("tie_grant_count", grants.size(), 4);
    if (grants.size() == 4)
      for (int i = 0; i < 4; i++) check($sformatf("tie_grant_%0d", i), grants[i], exp_order[i]);

    // Reset after the third step of a 10-step increment.
    cnt_val = 0;
    clear_tally();
    drive_client(0, 1'b1, 1'b0, 1'b0, 8'd10, '0);
    for (int i = 0; i < 200 && n_req < 3; i++) tick();
    check("abort_third_request", n_req, 3);
    Rst = 1'b1;
    drive_client(0, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    check("abort_Busy", Busy, 0);
    check("abort_outputs", {Ack0, Ack1, Done0, Done1, CntRequest, CntDec, CntSet}, 0);
    check("abort_CntIn", CntIn, 0);
    tick();
    Rst = 1'b0;
    repeat (10) tick();
    check("abort_no_done", n_done[0], 0);
    check("abort_counter", cnt_val, 3);

    // Random traffic with Ready stalls and occasional resets.
    busy_max = 3; glitch_pct = 20;
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 2; k++)
        if (!pend[k] && $urandom_range(0, 3) == 0) begin
          pend[k] = 1;
          drive_client(k, 1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                       STEP_W'($urandom_range(0, 4)), rand_bcd());
        end
      Rst = ($urandom_range(0, 399) == 0);
      tick();
      for (int k = 0; k < 2; k++)
        if (Rst || exp_done[k]) begin
          pend[k] = 0;
          drive_client(k, 1'b0, 1'b0, 1'b0, '0, '0);
        end
    end
    Rst = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dekatron_counter_arbiter.md
# dekatron_counter_arbiter

Sequencer and two-client arbiter for a single `DekatronCounter`. Each client submits a command: increment by N, decrement by N, or parallel set. The block grants one client at a time and drives the counter's `Request`/`Dec`/`Set`/`In` strobes, one step per counter handshake. It signals completion back to the granted client. It sits between the instruction-pointer/loop logic and a shared counter instance.

## Interface
Parameters:
- `D_NUM`, 6, number of dekatrons in the counter; data width is `D_NUM*4`.
- `STEP_W`, 8, width of the step-count field.

Ports:
- `Clk`  in  1  system clock; single clock domain.
- `Rst`  in  1  asynchronous, active-high reset.
- `Req0`, `Req1`  in  1  client request, level; must be held until the matching `Done`.
- `Dec0`, `Dec1`  in  1  direction: 1 = decrement, 0 = increment.
- `Set0`, `Set1`  in  1  parallel load of `In`; `Dec` and `Steps` are ignored when `Set` is 1.
- `Steps0`, `Steps1`  in  `STEP_W`  number of unit steps to perform.
- `In0`, `In1`  in  `D_NUM*4`  BCD load value.
- `Ack0`, `Ack1`  out  1  one-cycle pulse when the command is latched.
- `Done0`, `Done1`  out  1  one-cycle pulse when the command is complete.
- `Busy`  out  1  high in every state except IDLE.
- `CntRequest`  out  1  one-cycle request strobe to the counter.
- `CntDec`, `CntSet`  out  1  latched command bits to the counter.
- `CntIn`  out  `D_NUM*4`  latched load value.
- `CntReady`  in  1  counter `Ready`.

## Operation
- FSM states: IDLE, ISSUE, LAT, WAIT, DONE.
- IDLE:
  - If any `Req` is high, select a winner, latch `Dec`/`Set`/`Steps`/`In` and the owner id, and pulse `Ack`.
  - Set/Steps dispatch:
    - `Set` = 1: remaining := 1 → ISSUE.
    - `Steps` = 0 and `Set` = 0: → DONE. The counter is never touched.
    - Otherwise: remaining := `Steps` → ISSUE.
- ISSUE: if `CntReady` = 1, assert `CntRequest` for this one cycle and go to LAT. Otherwise stay in ISSUE.
- LAT: one dead cycle, because `CntReady` may still show the pre-request value. Always → WAIT.
- WAIT:
  - On `CntReady` = 1: remaining := remaining−1. If the new value is 0 → DONE, else → ISSUE.
  - Otherwise stay in WAIT.
- DONE: pulse the owner's `Done` → IDLE.
- `CntDec`, `CntSet`, `CntIn` hold the latched values from grant through DONE and stay stable while `CntRequest` is high.
- The remaining counter is `STEP_W` bits. It never underflows because zero-step commands bypass the counter.
- A `Req` still high in the IDLE cycle after `Done` is a new command.
- A `Req` dropped before `Done` is a protocol violation. The command still runs to completion.
- This block never resets the counter and never inspects counter `Out`.

## Timing
- Reset values: `Ack*`=0, `Done*`=0, `Busy`=0, `CntRequest`=0, `CntDec`=0, `CntSet`=0, `CntIn`=0, state IDLE, remaining 0, round-robin pointer = client 0.
- `Rst` asserted mid-operation immediately forces all outputs to their reset values. No `Done` is produced for the aborted command; the counter keeps whatever steps already completed.
- Grant in cycle t with `CntReady` constantly 1:
  - `CntRequest` at t+1.
  - LAT at t+2.
  - WAIT sees ready at t+3.
  - Next `CntRequest` at t+4, so 3 cycles per step.
  - For a one-step command, `Done` at t+4; next grant possible at t+5.
- N-step command with an always-ready counter: `Done` at t+3N+1.
- Zero-step command: `Done` at t+1.
- `CntReady` low stalls ISSUE or WAIT indefinitely, with no timeout.
- Simultaneous `Req0` and `Req1` in IDLE are resolved by the arbitration policy (see Configuration). Exactly one `Ack` pulses per grant.

## Configuration
- `DEKATRON_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration: on a tie, grant the client that was not granted most recently.
  - The pointer updates at each grant.
- `DEKATRON_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: client 0 always wins a tie.
  - The pointer register is not implemented.

## Test plan
- Counter at 0, `Req0` inc with `Steps0`=5 → exactly 5 `CntRequest` pulses with `CntDec`=0, one `Ack0`, one `Done0`; counter `Out` = 000005.
- Counter at 000005, `Req1` dec with `Steps1`=5 → 5 pulses with `CntDec`=1; `Out` = 000000; `Done1` only, `Done0` stays 0.
- `Req0` `Set`=1 with `In0`=0x123456 and `Steps0`=9 → exactly one `CntRequest` with `CntSet`=1 and `CntIn`=0x123456; `Out` = 123456.
- `Req0` with `Steps0`=0 → `Ack0` at t, `Done0` at t+1, `CntRequest` never asserted.
- `Req0` and `Req1` both held for two 1-step commands each:
  - RR build: grant order 0,1,0,1.
  - Fixed build: grant order 0,0 while `Req0` is held, then 1.
- `Steps0`=10, `Rst` pulsed after the 3rd `CntRequest` → all outputs 0 in the same cycle, no `Done0`, FSM in IDLE; `Out` = 000003.
